// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port memory bank between three requesters
// (0 = loader, 1 = multiply sequencer, 2 = output reader).
//
// Grants are burst-locked round-robin. The owner keeps the port until it
// flags the last beat of its burst, or until it has stalled (req low while
// granted) for IDLE_TO consecutive cycles. Every release is followed by one
// dead cycle in which IDLE re-arbitrates. The round-robin pointer then moves
// to the requester after the one that just released.
//
// Ports
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_req[2:0]     per-requester access request
//   i_wr[2:0]      per-requester beat type (1 = write, 0 = read)
//   i_last[2:0]    per-requester last-beat-of-burst flag
//   i_addr         packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   i_wdata        packed write data, requester i at [i*DATA_W +: DATA_W]
//   o_gnt[2:0]     one-hot grant (registered)
//   o_rvalid[2:0]  one-hot read-data-valid (registered)
//   o_rdata        read data, meaningful only while an o_rvalid bit is high
//   o_mem_*        memory pins, driven combinationally from the owner's beat
//   i_mem_rdata    memory read data, valid the cycle after a read enable
//   o_busy         high while a requester owns the port
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int IDLE_TO = 4    // legal range 1..15
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [2:0]            i_req,
    input  logic [2:0]            i_wr,
    input  logic [2:0]            i_last,
    input  logic [3*ADDR_W-1:0]   i_addr,
    input  logic [3*DATA_W-1:0]   i_wdata,
    output logic [2:0]            o_gnt,
    output logic [2:0]            o_rvalid,
    output logic [DATA_W-1:0]     o_rdata,
    output logic                  o_mem_en,
    output logic                  o_mem_ren,
    output logic                  o_mem_wen,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [DATA_W-1:0]     o_mem_wdata,
    input  logic [DATA_W-1:0]     i_mem_rdata,
    output logic                  o_busy
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    localparam logic [3:0] STALL_LIMIT = 4'(IDLE_TO);

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t      r_state;
    logic [1:0]  r_owner;
    logic [1:0]  r_ptr;
    logic [3:0]  r_stall;
    logic [2:0]  r_gnt;
    logic [2:0]  r_rvalid;
    logic        r_busy;

    // -------------------------------------------------------------------------
    // Helpers: modulo-3 increment and one-hot encode of a 0..2 index
    // -------------------------------------------------------------------------
    function automatic logic [1:0] inc_mod3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    function automatic logic [2:0] to_onehot(input logic [1:0] x);
        return 3'b001 << x;
    endfunction

    // First set request scanning ptr, ptr+1, ptr+2 (mod 3). Only meaningful
    // when at least one request bit is set.
    function automatic logic [1:0] rr_pick(input logic [2:0] req,
                                           input logic [1:0] ptr);
        logic [1:0] p1;
        logic [1:0] p2;
        p1 = inc_mod3(ptr);
        p2 = inc_mod3(p1);
        if (req[ptr])     return ptr;
        else if (req[p1]) return p1;
        else              return p2;
    endfunction

    // -------------------------------------------------------------------------
    // Owner input selection
    // -------------------------------------------------------------------------
    logic                w_own_req;
    logic                w_own_wr;
    logic                w_own_last;
    logic [ADDR_W-1:0]   w_own_addr;
    logic [DATA_W-1:0]   w_own_wdata;

    // NOTE: every signal assigned in an always_comb gets a default first so
    // that no path leaves it unassigned, which would infer a latch.
    always_comb begin
        w_own_req   = i_req[0];
        w_own_wr    = i_wr[0];
        w_own_last  = i_last[0];
        w_own_addr  = i_addr[0 +: ADDR_W];
        w_own_wdata = i_wdata[0 +: DATA_W];
        case (r_owner)
            2'd1: begin
                w_own_req   = i_req[1];
                w_own_wr    = i_wr[1];
                w_own_last  = i_last[1];
                w_own_addr  = i_addr[ADDR_W +: ADDR_W];
                w_own_wdata = i_wdata[DATA_W +: DATA_W];
            end
            2'd2: begin
                w_own_req   = i_req[2];
                w_own_wr    = i_wr[2];
                w_own_last  = i_last[2];
                w_own_addr  = i_addr[2*ADDR_W +: ADDR_W];
                w_own_wdata = i_wdata[2*DATA_W +: DATA_W];
            end
            default: ;
        endcase
    end

    // A beat is any granted cycle in which the owner is requesting; all
    // memory activity and all burst bookkeeping keys off this single term.
    logic        w_beat;
    logic        w_release;
    logic [3:0]  w_stall_nx;
    logic [1:0]  w_pick;

    assign w_beat = (r_state == S_OWN) && w_own_req;

    // Stall count after this cycle if it is a bubble, saturating at the limit.
    assign w_stall_nx = (r_stall >= STALL_LIMIT) ? STALL_LIMIT : r_stall + 4'd1;

    // Burst end and forced release share one path. A beat clears the stall
    // counter, so the two causes can never coincide.
    assign w_release = (r_state == S_OWN) &&
                       ( w_beat ? w_own_last : (w_stall_nx == STALL_LIMIT) );

    assign w_pick = rr_pick(i_req, r_ptr);

    // -------------------------------------------------------------------------
    // Memory pins: pass the owner's beat straight through, quiet otherwise
    // -------------------------------------------------------------------------
    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_ren   = 1'b0;
        o_mem_wen   = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (w_beat) begin
            o_mem_en    = 1'b1;
            o_mem_wen   = w_own_wr;
            o_mem_ren   = ~w_own_wr;
            o_mem_addr  = w_own_addr;
            o_mem_wdata = w_own_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Arbitration FSM with registered grant / valid / busy
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_owner  <= 2'd0;
            r_ptr    <= 2'd0;
            r_stall  <= 4'd0;
            r_gnt    <= 3'b000;
            r_rvalid <= 3'b000;
            r_busy   <= 1'b0;
        end else begin
            // Read return is tagged with the owner at issue time, so data is
            // still delivered when the same beat also released the grant.
            r_rvalid <= (w_beat && !w_own_wr) ? to_onehot(r_owner) : 3'b000;

            case (r_state)
                S_IDLE: begin
                    if (|i_req) begin
                        r_state <= S_OWN;
                        r_owner <= w_pick;
                        r_gnt   <= to_onehot(w_pick);
                        r_busy  <= 1'b1;
                        r_stall <= 4'd0;
                    end
                end

                S_OWN: begin
                    if (w_release) begin
                        r_state <= S_IDLE;
                        r_gnt   <= 3'b000;
                        r_busy  <= 1'b0;
                        r_ptr   <= inc_mod3(r_owner);
                        r_stall <= 4'd0;
                    end else if (w_beat) begin
                        r_stall <= 4'd0;
                    end else begin
                        r_stall <= w_stall_nx;
                    end
                end
            endcase
        end
    end

    assign o_gnt    = r_gnt;
    assign o_rvalid = r_rvalid;
    assign o_busy   = r_busy;

    // The memory returns data one cycle after the read enable, which is the
    // same cycle o_rvalid is high, so read data is forwarded unregistered.
    assign o_rdata  = i_mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Drives the arbiter against a small behavioural memory. Expected read
// returns are pushed into a scoreboard queue when a read beat is presented
// and popped by a monitor in the cycle the return is due.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 8;
    localparam int IDLE_TO = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [2:0]           req;
    logic [2:0]           wr;
    logic [2:0]           last;
    logic [ADDR_W-1:0]    addr_a  [3];
    logic [DATA_W-1:0]    wdata_a [3];
    logic [DATA_W-1:0]    mem_rdata;

    logic [3*ADDR_W-1:0]  addr_bus;
    logic [3*DATA_W-1:0]  wdata_bus;
    logic [2:0]           gnt;
    logic [2:0]           rvalid;
    logic [DATA_W-1:0]    rdata;
    logic                 mem_en;
    logic                 mem_ren;
    logic                 mem_wen;
    logic [ADDR_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    mem_wdata;
    logic                 busy;

    assign addr_bus  = {addr_a[2], addr_a[1], addr_a[0]};
    assign wdata_bus = {wdata_a[2], wdata_a[1], wdata_a[0]};

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .IDLE_TO (IDLE_TO)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_wr        (wr),
        .i_last      (last),
        .i_addr      (addr_bus),
        .i_wdata     (wdata_bus),
        .o_gnt       (gnt),
        .o_rvalid    (rvalid),
        .o_rdata     (rdata),
        .o_mem_en    (mem_en),
        .o_mem_ren   (mem_ren),
        .o_mem_wen   (mem_wen),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .o_busy      (busy)
    );

    // Behavioural single-port memory (low 256 words are all the bench uses)
    logic [7:0] mem     [256];
    logic [7:0] exp_mem [256];

    always @(posedge clk) begin
        if (mem_en && mem_ren) mem_rdata <= mem[mem_addr[7:0]];
        if (mem_en && mem_wen) mem[mem_addr[7:0]] <= mem_wdata;
    end

    // -------------------------------------------------------------------------
    // Counters, check task, scoreboard
    // -------------------------------------------------------------------------
    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int         due;
        int         who;
        logic [7:0] data;
    } rd_exp_t;

    rd_exp_t rd_q[$];

    function automatic logic [2:0] oh(input int i);
        return 3'(1 << i);
    endfunction

    // Read-return monitor
    always @(negedge clk) begin
        rd_exp_t e;
        while (rd_q.size() > 0 && rd_q[0].due < cyc) begin
            e = rd_q.pop_front();
            check("rvalid_missing", 32'(rvalid), 32'(oh(e.who)));
        end
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            e = rd_q.pop_front();
            check("rvalid", 32'(rvalid), 32'(oh(e.who)));
            check("rdata", 32'(rdata), 32'(e.data));
        end else if (rvalid != 3'b000) begin
            check("rvalid_spurious", 32'(rvalid), 32'd0);
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers (drive just after posedge, sample on negedge)
    // -------------------------------------------------------------------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive_beat(input int id, input bit is_wr,
                              input logic [15:0] a, input logic [7:0] d,
                              input bit is_last);
        req[id]     = 1'b1;
        wr[id]      = is_wr;
        last[id]    = is_last;
        addr_a[id]  = a;
        wdata_a[id] = d;
    endtask

    task automatic drop(input int id);
        req[id]  = 1'b0;
        wr[id]   = 1'b0;
        last[id] = 1'b0;
    endtask

    // Called at a negedge during an expected beat of requester id.
    task automatic check_beat(input int id, input bit is_wr,
                              input logic [15:0] a, input logic [7:0] d);
        check("beat_gnt", 32'(gnt), 32'(oh(id)));
        check("beat_busy", 32'(busy), 32'd1);
        check("beat_en", 32'(mem_en), 32'd1);
        check("beat_wen", 32'(mem_wen), 32'(is_wr));
        check("beat_ren", 32'(mem_ren), 32'(!is_wr));
        check("beat_addr", 32'(mem_addr), 32'(a));
        if (is_wr) begin
            check("beat_wdata", 32'(mem_wdata), 32'(d));
            exp_mem[a[7:0]] = d;
        end else begin
            rd_q.push_back('{due: cyc + 1, who: id, data: exp_mem[a[7:0]]});
        end
    endtask

    // Waits (bounded) for any grant; returns the number of ungranted samples.
    task automatic wait_gnt(input string tag, input logic [2:0] exp,
                            output int lat);
        bit seen;
        lat  = 0;
        seen = 1'b0;
        for (int t = 0; t < 16; t++) begin
            sample();
            if (gnt != 3'b000) begin
                seen = 1'b1;
                break;
            end
            lat++;
            next_cycle();
        end
        if (!seen) sample();
        check(tag, 32'(gnt), 32'(exp));
    endtask

    task automatic run_burst(input int id, input int n, input bit is_wr,
                             input logic [15:0] a0, input logic [7:0] d0);
        int lat;
        drive_beat(id, is_wr, a0, d0, n == 1);
        wait_gnt("burst_gnt", oh(id), lat);
        for (int b = 0; b < n; b++) begin
            check_beat(id, is_wr, 16'(a0 + 16'(b)), 8'(d0 + 8'(b)));
            next_cycle();
            if (b < n - 1) begin
                drive_beat(id, is_wr, 16'(a0 + 16'(b + 1)),
                           8'(d0 + 8'(b + 1)), (b + 1) == (n - 1));
                sample();
            end
        end
        drop(id);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Main sequence
    // -------------------------------------------------------------------------
    initial begin
        int lat;
        int order [6];
        int g;
        int gap;

        rst  = 1'b1;
        req  = '0;
        wr   = '0;
        last = '0;
        for (int i = 0; i < 3; i++) begin
            addr_a[i]  = '0;
            wdata_a[i] = '0;
        end
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i * 7 + 3);
            exp_mem[i] = 8'(i * 7 + 3);
        end
        mem[5]     = 8'hA7;
        exp_mem[5] = 8'hA7;

        // Reset state
        next_cycle();
        next_cycle();
        sample();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_wen", 32'(mem_wen), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        next_cycle();
        rst = 1'b0;

        // Single read by requester 1 at word 5
        drive_beat(1, 1'b0, 16'h0005, 8'h00, 1'b1);
        wait_gnt("t1_gnt", 3'b010, lat);
        check("t1_latency", 32'(lat), 32'd1);
        check_beat(1, 1'b0, 16'h0005, 8'h00);
        next_cycle();
        drop(1);
        sample();
        check("t1_release", 32'(gnt), 32'd0);
        check("t1_ren_once", 32'(mem_ren), 32'd0);
        check("t1_rdata", 32'(rdata), 32'hA7);
        next_cycle();

        // 9-beat write burst by requester 0
        run_burst(0, 9, 1'b1, 16'h0000, 8'h10);
        sample();
        check("t2_release", 32'(gnt), 32'd0);
        check("t2_busy", 32'(busy), 32'd0);
        next_cycle();

        // ptr must now be 1: with 0 and 2 requesting, 2 wins
        drive_beat(0, 1'b0, 16'h0003, 8'h00, 1'b1);
        drive_beat(2, 1'b0, 16'h0022, 8'h00, 1'b1);
        wait_gnt("t2_ptr_is_1", 3'b100, lat);
        check_beat(2, 1'b0, 16'h0022, 8'h00);
        next_cycle();
        drop(2);
        sample();
        check("t2_dead", 32'(gnt), 32'd0);
        next_cycle();
        sample();
        check("t2_next", 32'(gnt), 32'b001);
        check_beat(0, 1'b0, 16'h0003, 8'h00);   // reads back written 0x13
        next_cycle();
        drop(0);

        // Round-robin fairness from a fresh reset
        do_reset();
        order = '{0, 1, 2, 0, 1, 2};
        for (int i = 0; i < 3; i++)
            drive_beat(i, 1'b0, 16'(16'h0040 + 16'(i)), 8'h00, 1'b1);
        g   = 0;
        gap = 0;
        for (int t = 0; t < 40 && g < 6; t++) begin
            sample();
            if (gnt != 3'b000) begin
                check("rr_order", 32'(gnt), 32'(oh(order[g])));
                check("rr_gap", 32'(gap), 32'd1);
                check_beat(order[g], 1'b0, 16'(16'h0040 + 16'(order[g])), 8'h00);
                g++;
                gap = 0;
            end else begin
                gap++;
            end
            next_cycle();
        end
        check("rr_count", 32'(g), 32'd6);
        for (int i = 0; i < 3; i++) drop(i);
        sample();
        check("rr_idle", 32'(gnt), 32'd0);
        next_cycle();

        // Stall timeout by requester 2, requester 0 waiting
        drive_beat(2, 1'b0, 16'h0050, 8'h00, 1'b0);
        wait_gnt("t4_gnt", 3'b100, lat);
        check_beat(2, 1'b0, 16'h0050, 8'h00);
        next_cycle();
        drop(2);
        drive_beat(0, 1'b0, 16'h0051, 8'h00, 1'b1);
        for (int s = 0; s < IDLE_TO; s++) begin
            sample();
            check("t4_stall_gnt", 32'(gnt), 32'b100);
            check("t4_stall_en", 32'(mem_en), 32'd0);
            next_cycle();
        end
        sample();
        check("t4_release", 32'(gnt), 32'd0);
        next_cycle();
        sample();
        check("t4_next", 32'(gnt), 32'b001);
        check_beat(0, 1'b0, 16'h0051, 8'h00);
        next_cycle();
        drop(0);

        // Read at release: return lands in the dead cycle
        drive_beat(1, 1'b0, 16'h0060, 8'h00, 1'b1);
        drive_beat(0, 1'b0, 16'h0061, 8'h00, 1'b1);
        wait_gnt("t5_gnt", 3'b010, lat);
        check_beat(1, 1'b0, 16'h0060, 8'h00);
        next_cycle();
        drop(1);
        sample();
        check("t5_dead_gnt", 32'(gnt), 32'd0);
        check("t5_dead_rvalid", 32'(rvalid), 32'b010);
        next_cycle();
        sample();
        check("t5_next", 32'(gnt), 32'b001);
        check_beat(0, 1'b0, 16'h0061, 8'h00);
        next_cycle();
        drop(0);

        // Reset in the cycle after the first read beat of a 4-beat burst
        drive_beat(1, 1'b0, 16'h0070, 8'h00, 1'b0);
        wait_gnt("t6_gnt", 3'b010, lat);
        check_beat(1, 1'b0, 16'h0070, 8'h00);
        next_cycle();
        drive_beat(1, 1'b0, 16'h0071, 8'h00, 1'b0);
        rst = 1'b1;
        sample();
        next_cycle();
        rst = 1'b0;
        drive_beat(1, 1'b0, 16'h0072, 8'h00, 1'b1);
        drive_beat(2, 1'b0, 16'h0073, 8'h00, 1'b1);
        sample();
        check("t6_rst_gnt", 32'(gnt), 32'd0);
        check("t6_rst_rvalid", 32'(rvalid), 32'd0);
        check("t6_rst_mem_en", 32'(mem_en), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        next_cycle();
        sample();
        check("t6_ptr_is_0", 32'(gnt), 32'b010);
        check_beat(1, 1'b0, 16'h0072, 8'h00);
        next_cycle();
        drop(1);
        drop(2);
        sample();
        check("t6_release", 32'(gnt), 32'd0);

        repeat (3) next_cycle();
        sample();
        check("sb_drain", 32'(rd_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port matrix memory (m1, m2 or m3 bank) between three requesters: 0 = loader, 1 = multiply sequencer, 2 = output reader.
- Grants are burst-locked round-robin: a requester keeps the port until it flags its last beat, or until it stalls past a timeout.
- Sits between the requesting controllers and the memory's en/ren/wen/addr/data pins.
- One instance per memory bank.

Parameters:
- ADDR_W, 16, address width (m + n).
- DATA_W, 8, memory data width.
- IDLE_TO, 4, consecutive stalled cycles by the owner before a forced release (legal range 1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req  in  3  per-requester access request; bit i = requester i.
- wr  in  3  per-requester beat type: 1 = write, 0 = read.
- last  in  3  per-requester last-beat-of-burst flag.
- addr  in  3*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- wdata  in  3*DATA_W  packed write data, same packing as addr.
- gnt  out  3  one-hot grant, registered.
- rvalid  out  3  one-hot read-data-valid, registered.
- rdata  out  DATA_W  read data; meaningful only when an rvalid bit is high.
- mem_en  out  1  memory enable.
- mem_ren  out  1  memory read enable.
- mem_wen  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid the cycle after a read enable.
- busy  out  1  high while in state OWN.

Behaviour:
Reset (synchronous, rst=1 at a clock edge):
- state=IDLE, gnt=0, rvalid=0, owner=0, ptr=0, stall counter=0, busy=0.
- All mem_* outputs read 0 after the edge.
- Reset mid-burst aborts the burst immediately. A read issued in the cycle before reset produces no rvalid.

State IDLE:
- If req != 0, select the first set bit scanning ptr, ptr+1, ptr+2 (mod 3).
- Register that requester as owner, set gnt to the one-hot owner value, go to OWN.
- Grant latency: req high at edge N gives gnt high after edge N+1 (one cycle).
- No memory access occurs while in IDLE.

State OWN:
- gnt[owner]=1 and busy=1.
- Beat definition: a beat is any cycle with gnt[owner] & req[owner].
- Memory outputs are combinational from the owner's inputs:
  - On a beat: mem_en=1, mem_wen=wr[owner], mem_ren=~wr[owner], mem_addr=owner's addr slice, mem_wdata=owner's wdata slice.
  - Otherwise: all mem_* = 0.
- Read return: a read beat at edge N gives rvalid[owner]=1 and rdata=mem_rdata for the cycle after edge N+1, exactly one cycle.
  - The read is tied to the owner captured at issue time, so it is delivered even if the grant has already been released.
- Burst end: a beat with last[owner]=1 is the final beat.
  - Next state is IDLE, gnt=0, ptr=(owner+1) mod 3, stall counter=0.
  - The cycle after release is a dead cycle: IDLE re-arbitrates, and the new grant appears one cycle later.
  - Minimum gap between bursts of different owners: 1 idle memory cycle.
- Stall handling: owner req=0 while granted is a bubble with no memory access, and the stall counter increments.
  - The counter clears on any beat.
  - When the counter reaches IDLE_TO, the grant is forced off: same actions as burst end, ptr=owner+1.
- Single-beat burst: a beat with last=1 on the first granted cycle is legal.

Input qualification:
- Non-owner requests are ignored while in OWN. They are not queued; a requester must hold req until it sees gnt.
- last and wr are sampled only on beats.
- last asserted with req=0 is ignored.

Width and arithmetic:
- ptr and owner are 2 bits and take values 0..2 only; wrap is 2 -> 0.
- The stall counter is 4 bits and saturates at IDLE_TO.

Simultaneous events:
- rst has priority over everything.
- Forced release and a beat cannot coincide, because a beat clears the stall counter.

Test Plan:
- Reset and single read: rst for 2 cycles. Assert req=3'b010, wr=0, last=1, addr1=0x0005, with memory word 5 preloaded to 0xA7. Expect gnt=3'b010 one cycle after req; mem_ren=1 and mem_addr=0x0005 for 1 cycle; rvalid=3'b010 with rdata=0xA7 the next cycle; gnt=0 after that.
- Write burst: requester 0 writes 9 beats to addresses 0..8 with data 0x10..0x18, last on beat 9. Expect 9 consecutive mem_wen cycles, gnt held throughout, release after beat 9, and ptr=1 (checked by the next test's arbitration).
- Round-robin fairness: hold req=3'b111 continuously, each burst 1 beat. Expect grant order 0,1,2,0,1,2 (starting from ptr=0 after reset), each grant separated by 1 idle cycle.
- Stall timeout: requester 2 is granted, does 1 non-last beat, then drops req. Expect gnt[2] to clear exactly after 4 stalled cycles (IDLE_TO=4) and no mem_en during the stall. Requester 0, waiting since before the stall, is granted next.
- Read at release: requester 1 issues a read with last=1 while requester 0 is waiting. Expect rvalid=3'b010 delivered in the dead cycle with gnt=0, and gnt=3'b001 the cycle after.
- Reset mid-burst: assert rst in the cycle after a read beat of a 4-beat burst. Expect gnt=0, rvalid=0 and mem_en=0 after the edge, and fresh arbitration from ptr=0 afterwards.
